// File: rtl/can_crc_tx_if.sv
// Frame-builder to CAN transmitter signal bundle.
// Optional ACK readback signals exist only when CAN_TX_ACK_CHECK_EN is defined.
interface can_crc_tx_if;
    logic        i_Start;
    logic [10:0] i_ID;
    logic        i_RTR;
    logic [3:0]  i_DLC;
    logic [63:0] i_Data;
    logic        o_Tx;
    logic        o_Busy;
    logic        o_Done;
    logic [14:0] o_CRC;
`ifdef CAN_TX_ACK_CHECK_EN
    logic        i_Rx;
    logic        o_AckErr;

    modport slave (
        input  i_Start, i_ID, i_RTR, i_DLC, i_Data, i_Rx,
        output o_Tx, o_Busy, o_Done, o_CRC, o_AckErr
    );
    modport master (
        output i_Start, i_ID, i_RTR, i_DLC, i_Data, i_Rx,
        input  o_Tx, o_Busy, o_Done, o_CRC, o_AckErr
    );
`else
    modport slave (
        input  i_Start, i_ID, i_RTR, i_DLC, i_Data,
        output o_Tx, o_Busy, o_Done, o_CRC
    );
    modport master (
        output i_Start, i_ID, i_RTR, i_DLC, i_Data,
        input  o_Tx, o_Busy, o_Done, o_CRC
    );
`endif
endinterface

// File: rtl/can_crc_tx.sv
// CAN 2.0A standard-frame serializer with on-the-fly CRC-15 and bit stuffing.
// Define CAN_TX_ACK_CHECK_EN to add ACK-slot readback (i_Rx) and o_AckErr.
module can_crc_tx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    can_crc_tx_if.slave  tx_if
);
    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, FRAME, CRC, TAIL} state_t;

    state_t            state_q, state_d;
    logic [10:0]       id_q;
    logic              rtr_q;
    logic [3:0]        dlc_q;
    logic [63:0]       data_q;
    logic [6:0]        idx_q, idx_d;
    logic [2:0]        run_q, run_d;
    logic              last_q;
    logic              stuff_q, stuff_d;
    logic [DIV_W-1:0]  div_q;
    logic [14:0]       crc_q, crc_d;
    logic              tx_q, tx_d;
    logic              busy_q;
    logic              done_q;

    logic [3:0]        nbytes;
    logic [6:0]        frame_len;
    logic [82:0]       frame_vec;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic inv;
        inv = b ^ c[14];
        return {c[13:0], 1'b0} ^ (inv ? 15'h4599 : 15'h0000);
    endfunction

    always_comb begin
        nbytes    = rtr_q ? 4'd0 : ((dlc_q > 4'd8) ? 4'd8 : dlc_q);
        frame_len = 7'd19 + {nbytes, 3'b000};
        frame_vec = {1'b0, id_q, rtr_q, 1'b0, 1'b0, dlc_q, data_q};

        // Stuff bits count toward the run but never reach the CRC.
        run_d = (tx_q == last_q) ? run_q + 3'd1 : 3'd1;
        crc_d = (state_q == FRAME && !stuff_q) ? crc_step(crc_q, tx_q) : crc_q;

        state_d = state_q;
        idx_d   = idx_q;
        if (!stuff_q) begin
            idx_d = idx_q + 7'd1;
            case (state_q)
                FRAME:   if (idx_d == frame_len) begin state_d = CRC;  idx_d = 7'd0; end
                CRC:     if (idx_d == 7'd15)     begin state_d = TAIL; idx_d = 7'd0; end
                TAIL:    if (idx_d == 7'd10)     begin state_d = IDLE; idx_d = 7'd0; end
                default: ;
            endcase
        end

        // A stuff bit due after the last CRC bit goes out while already in TAIL.
        stuff_d = !stuff_q && (state_q == FRAME || state_q == CRC) && (run_d == 3'd5);

        case (state_d)
            FRAME:   tx_d = frame_vec[7'd82 - idx_d];
            CRC:     tx_d = crc_d[4'd14 - idx_d[3:0]];
            default: tx_d = 1'b1;
        endcase
        if (stuff_d) tx_d = ~tx_q;
    end

`ifdef CAN_TX_ACK_CHECK_EN
    logic ack_miss_q;
    logic ack_err_q;
`endif

    always_ff @(posedge i_Clk) begin
        if (state_q == IDLE && tx_if.i_Start) begin
            id_q   <= tx_if.i_ID;
            rtr_q  <= tx_if.i_RTR;
            dlc_q  <= tx_if.i_DLC;
            data_q <= tx_if.i_Data;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            idx_q   <= 7'd0;
            run_q   <= 3'd0;
            last_q  <= 1'b1;
            stuff_q <= 1'b0;
            div_q   <= '0;
            crc_q   <= 15'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CAN_TX_ACK_CHECK_EN
            ack_miss_q <= 1'b0;
            ack_err_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef CAN_TX_ACK_CHECK_EN
            ack_err_q <= 1'b0;
            if (state_q == TAIL && !stuff_q && idx_q == 7'd1 &&
                div_q == DIV_W'(CLKS_PER_BIT / 2))
                ack_miss_q <= tx_if.i_Rx;
`endif
            case (state_q)
                IDLE: begin
                    if (tx_if.i_Start) begin
                        state_q <= FRAME;
                        idx_q   <= 7'd0;
                        run_q   <= 3'd0;
                        last_q  <= 1'b1;
                        stuff_q <= 1'b0;
                        div_q   <= '0;
                        crc_q   <= 15'd0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef CAN_TX_ACK_CHECK_EN
                        ack_miss_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        crc_q   <= crc_d;
                        run_q   <= run_d;
                        last_q  <= tx_q;
                        stuff_q <= stuff_d;
                        state_q <= state_d;
                        idx_q   <= idx_d;
                        tx_q    <= tx_d;
                        if (state_d == IDLE) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
`ifdef CAN_TX_ACK_CHECK_EN
                            ack_err_q <= ack_miss_q;
`endif
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx_if.o_Tx   = tx_q;
    assign tx_if.o_Busy = busy_q;
    assign tx_if.o_Done = done_q;
    assign tx_if.o_CRC  = crc_q;
`ifdef CAN_TX_ACK_CHECK_EN
    assign tx_if.o_AckErr = ack_err_q;
`endif
endmodule

// File: tb/tb_can_crc_tx.sv
// Bench for can_crc_tx: table-driven frames, corner sequences and random frames
// against a queue-based reference model (CRC by polynomial long division).
module tb_can_crc_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    can_crc_tx_if dif();
    can_crc_tx #(.CLKS_PER_BIT(CPB)) dut (.i_Clk(clk), .i_Rst(rst), .tx_if(dif));

    int n_cmp = 0;
    int n_bad = 0;

    bit          exp_q[$];
    logic [14:0] exp_crc;
    int          db10_pos;
    bit          cap_q[$];
    bit          ds_q[$];

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        int          exp_data_bits;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Remainder of m(x)*x^15 divided by x^15+x^14+x^10+x^8+x^7+x^4+x^3+1.
    function automatic logic [14:0] crc_div(input bit m[$]);
        bit w[$];
        logic [15:0] g;
        logic [14:0] r;
        g = 16'hC599;
        w = m;
        repeat (15) w.push_back(1'b0);
        for (int i = 0; i < m.size(); i++)
            if (w[i])
                for (int j = 0; j < 16; j++) w[i+j] = w[i+j] ^ g[15-j];
        for (int k = 0; k < 15; k++) r[14-k] = w[m.size()+k];
        return r;
    endfunction

    function automatic void build_model(input logic [10:0] id, input logic rtr,
                                        input logic [3:0] dlc, input logic [63:0] data);
        bit raw[$];
        int nb, run;
        bit last;
        nb = rtr ? 0 : ((dlc > 8) ? 8 : int'(dlc));
        raw = {};
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        for (int i = 0; i < nb * 8; i++) raw.push_back(data[63-i]);
        exp_crc = crc_div(raw);
        for (int i = 14; i >= 0; i--) raw.push_back(exp_crc[i]);
        exp_q = {};
        run = 0;
        last = 1'b0;
        db10_pos = -1;
        for (int i = 0; i < raw.size(); i++) begin
            if (i == 29) db10_pos = exp_q.size();
            exp_q.push_back(raw[i]);
            run = (run > 0 && raw[i] == last) ? run + 1 : 1;
            last = raw[i];
            if (run == 5) begin
                exp_q.push_back(!last);
                last = !last;
                run = 1;
            end
        end
        repeat (10) exp_q.push_back(1'b1);
    endfunction

    function automatic void destuff();
        int run;
        bit last, skip;
        ds_q = {};
        run = 0;
        last = 1'b0;
        skip = 1'b0;
        for (int i = 0; i + 10 < cap_q.size(); i++) begin
            if (skip) begin
                skip = 1'b0;
                run = 1;
                last = cap_q[i];
            end else begin
                ds_q.push_back(cap_q[i]);
                run = (run > 0 && cap_q[i] == last) ? run + 1 : 1;
                last = cap_q[i];
                if (run == 5) skip = 1'b1;
            end
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the SOF cycle.
    task automatic kick(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                        input logic [63:0] data);
        dif.i_ID = id;
        dif.i_RTR = rtr;
        dif.i_DLC = dlc;
        dif.i_Data = data;
        dif.i_Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.i_Start = 1'b0;
        dif.i_ID = ~id;
        dif.i_RTR = ~rtr;
        dif.i_DLC = ~dlc;
        dif.i_Data = ~data;
    endtask

    // Follows a frame from its SOF cycle to the o_Done cycle and compares with the model.
    task automatic watch_frame(input int glitch_cyc, input bit exp_ack);
        int c;
        int bad;
        c = 0;
        cap_q = {};
        while (dif.o_Busy) begin
            if (c == glitch_cyc) begin
                dif.i_Start = 1'b1;
                dif.i_ID = dif.i_ID ^ 11'h5A5;
            end else if (c == glitch_cyc + 1) begin
                dif.i_Start = 1'b0;
            end
            if (c % CPB == CPB / 2) cap_q.push_back(dif.o_Tx);
            c++;
            if (c > 4000) begin
                check("frame timeout", c, exp_q.size() * CPB);
                return;
            end
            @(negedge clk);
        end
        check("busy cycles", c, exp_q.size() * CPB);
        check("done pulse", dif.o_Done, 1);
        check("tx idle at done", dif.o_Tx, 1);
        check("final crc", dif.o_CRC, exp_crc);
`ifdef CAN_TX_ACK_CHECK_EN
        check("ack err", dif.o_AckErr, exp_ack);
`else
        if (exp_ack) check("ack expectation without feature", 0, 1);
`endif
        bad = -1;
        if (cap_q.size() != exp_q.size()) bad = cap_q.size();
        else
            for (int i = 0; i < cap_q.size(); i++)
                if (bad < 0 && cap_q[i] != exp_q[i]) bad = i;
        check("stream first bad bit", bad, -1);
        destuff();
        check("checker crc residue", (ds_q.size() > 34) || (ds_q.size() == 34) ? crc_div(ds_q) : 15'h7FFF, 0);
    endtask

    vec_t tab[7];

    initial begin
        logic [15:0] first16;
        logic [3:0]  dlc_seen;
        logic        done_seen;
        logic [10:0] rid;
        logic        rrtr;
        logic [3:0]  rdlc;
        logic [63:0] rdata;

        tab[0] = '{11'h000, 1'b0, 4'h0, 64'h0, 0};
        tab[1] = '{11'h7FF, 1'b1, 4'h4, 64'hDEAD_BEEF_0000_0000, 0};
        tab[2] = '{11'h3A5, 1'b0, 4'hF, 64'h0123_4567_89AB_CDEF, 64};
        tab[3] = '{11'h123, 1'b0, 4'h3, 64'hAABB_CC00_0000_0000, 24};
        tab[4] = '{11'h555, 1'b0, 4'h8, 64'hFFFF_FFFF_0000_0000, 64};
        tab[5] = '{11'h0F0, 1'b0, 4'h9, 64'h8000_0000_0000_0001, 64};
        tab[6] = '{11'h400, 1'b0, 4'h1, 64'hFF00_0000_0000_0000, 8};

        dif.i_Start = 1'b0;
        dif.i_ID = '0;
        dif.i_RTR = 1'b0;
        dif.i_DLC = '0;
        dif.i_Data = '0;
`ifdef CAN_TX_ACK_CHECK_EN
        dif.i_Rx = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset tx", dif.o_Tx, 1);
        check("reset busy", dif.o_Busy, 0);
        check("reset done", dif.o_Done, 0);
        check("reset crc", dif.o_CRC, 0);
`ifdef CAN_TX_ACK_CHECK_EN
        check("reset ackerr", dif.o_AckErr, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        foreach (tab[k]) begin
            build_model(tab[k].id, tab[k].rtr, tab[k].dlc, tab[k].data);
            kick(tab[k].id, tab[k].rtr, tab[k].dlc, tab[k].data);
            check("sof tx", dif.o_Tx, 0);
            check("sof busy", dif.o_Busy, 1);
            watch_frame(-10, 1'b0);
            check("data bit count", int'(ds_q.size()) - 34, tab[k].exp_data_bits);
            dlc_seen = 4'h0;
            if (ds_q.size() >= 19) dlc_seen = {ds_q[15], ds_q[16], ds_q[17], ds_q[18]};
            check("dlc field", dlc_seen, tab[k].dlc);
            if (k == 1) begin
                first16 = '0;
                for (int i = 0; i < 16 && i < cap_q.size(); i++) first16[15-i] = cap_q[i];
                check("remote first 16 bits", first16, 16'b0111_1101_1111_0110);
            end
            @(negedge clk);
            check("done one cycle", dif.o_Done, 0);
        end

        // Reset during data bit 10 aborts silently; the next frame is unaffected.
        build_model(11'h2AA, 1'b0, 4'h2, 64'hC3A5_0000_0000_0000);
        kick(11'h2AA, 1'b0, 4'h2, 64'hC3A5_0000_0000_0000);
        repeat (db10_pos * CPB + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort tx", dif.o_Tx, 1);
        check("abort busy", dif.o_Busy, 0);
        check("abort crc", dif.o_CRC, 0);
        done_seen = dif.o_Done;
        repeat (8) begin
            @(negedge clk);
            done_seen = done_seen | dif.o_Done;
        end
        check("no done after abort", done_seen, 0);
        build_model(11'h2AA, 1'b0, 4'h2, 64'hC3A5_0000_0000_0000);
        kick(11'h2AA, 1'b0, 4'h2, 64'hC3A5_0000_0000_0000);
        watch_frame(-10, 1'b0);
        @(negedge clk);

        // Start while busy is ignored; back-to-back start in the done cycle.
        build_model(11'h0F0, 1'b0, 4'h2, 64'h1234_0000_0000_0000);
        kick(11'h0F0, 1'b0, 4'h2, 64'h1234_0000_0000_0000);
        watch_frame(30, 1'b0);
        build_model(11'h1C7, 1'b0, 4'h1, 64'h5A00_0000_0000_0000);
        kick(11'h1C7, 1'b0, 4'h1, 64'h5A00_0000_0000_0000);
        check("b2b sof tx", dif.o_Tx, 0);
        check("b2b sof busy", dif.o_Busy, 1);
        watch_frame(-10, 1'b0);
        @(negedge clk);

`ifdef CAN_TX_ACK_CHECK_EN
        build_model(11'h321, 1'b0, 4'h1, 64'h3C00_0000_0000_0000);
        dif.i_Rx = 1'b1;
        kick(11'h321, 1'b0, 4'h1, 64'h3C00_0000_0000_0000);
        watch_frame(-10, 1'b1);
        @(negedge clk);
        check("ackerr one cycle", dif.o_AckErr, 0);
        dif.i_Rx = 1'b0;
`endif

        for (int r = 0; r < 16; r++) begin
            rid = 11'($urandom);
            rrtr = ($urandom_range(3) == 0);
            rdlc = 4'($urandom);
            rdata = {$urandom, $urandom};
            build_model(rid, rrtr, rdlc, rdata);
            kick(rid, rrtr, rdlc, rdata);
            watch_frame(-10, 1'b0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
